exec_stage_pipe: RTL and testbench
==================================

Name: exec_stage_pipe

Overview:
Registered, parametrised execute stage for the ARM pipeline. It generates the ALU second operand (Val2), evaluates the ALU operation and the branch target, and holds a private NZCV status register. Results go to the MEM stage through a valid/ready output register. An optional iterative multiplier adds a multi-cycle operation, so the stage can stall the pipeline.

Parameters:
DATA_W, 32, datapath width (>=16, even)
IMM_W, 24, branch signed-immediate width
PC_W, 32, program-counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  ID/EX payload valid
in_ready  out  1  stage can accept payload this cycle
exe_cmd  in  4  ALU operation code
mem_read  in  1  load instruction
mem_write  in  1  store instruction
s_bit  in  1  update status register
pc  in  PC_W  PC of the next instruction
reg1  in  DATA_W  Rn value
reg2  in  DATA_W  Rm value
imm  in  1  immediate operand select
shift_operand  in  12  ARM shifter operand field
signed_imm  in  IMM_W  branch offset, in words
out_valid  out  1  EX/MEM payload valid
out_ready  in  1  MEM stage accepts payload
alu_result  out  DATA_W  registered ALU result
branch_addr  out  PC_W  registered pc + (sext(signed_imm) << 2), wraps modulo 2^PC_W
status  out  4  NZCV register {N,Z,C,V}
busy  out  1  multiply in progress

Behaviour:
- Reset: out_valid=0, alu_result=0, branch_addr=0, status=0, busy=0, FSM=IDLE. Reset overrides every other event, including mid-multiply (partial product discarded).
- Accept: fire = in_valid & in_ready. in_ready = (state==IDLE) & (!out_valid | out_ready).
- Val2 selection:
  - mem_read|mem_write: Val2 = zero-extended shift_operand[11:0].
  - Otherwise, if imm: Val2 = zero-extended shift_operand[7:0] rotated right by 2*shift_operand[11:8].
  - Otherwise: reg2 shifted by shift_operand[11:7] using type [6:5]: 00 LSL, 01 LSR, 10 ASR, 11 ROR. A shift of 0 passes reg2 unchanged.
- ALU ops (C_in = status.C):
  - 0001 MOV: Val2
  - 1001 MVN: ~Val2
  - 0010 ADD: reg1+Val2
  - 0011 ADC: +C_in
  - 0100 SUB: reg1-Val2
  - 0101 SBC: reg1-Val2-!C_in
  - 0110 AND
  - 0111 ORR
  - 1000 EOR
  - other codes: result 0
- Flags: N = result MSB; Z = (result==0).
  - Add ops: C = carry-out; V = signed overflow.
  - Subtract ops: C = NOT borrow; V = signed overflow.
  - Logic/MOV ops: C and V unchanged.
- Single-cycle op: on fire, the output register loads on the same edge, so out_valid=1 on the next cycle (latency 1).
- Status update: status updates on that same edge iff s_bit=1, and only for ops 0001-1001; the update is visible next cycle.
- Output hold: while out_valid & !out_ready, all outputs hold stable and in_ready=0.
- Simultaneous events: drain and a new fire in the same cycle is legal; back-to-back throughput is 1 per cycle.
- FSM states:
  - IDLE: on fire with a multiply, go to MUL.
  - MUL: busy=1, in_ready=0, one iteration per cycle for DATA_W/2 cycles (radix-4). Then load the output register and return to IDLE.
  - The output loads only when the output register is empty or draining. Otherwise MUL holds its final value until it can load.

Optional Feature:
Macro EXEC_MUL_EN.
- Defined: exe_cmd 0000 = MUL. Result is the low DATA_W bits of reg1*reg2. Latency is DATA_W/2+1 cycles from fire to out_valid. With s_bit, N and Z update while C and V are unchanged.
- Undefined: 0000 is a single-cycle op with result 0. The MUL state is absent, and busy is tied to 0.

Test Plan:
- ADD with S: reg1=0x7FFFFFFF, imm=1, shift_operand=0x001, s_bit=1 -> next cycle alu_result=0x80000000, status=N1 Z0 C0 V1.
- SUB with S: reg1=5, reg2=5, register Val2 with LSL 0, s_bit=1 -> result 0, status=N0 Z1 C1 V0. Then ADC reg1=1, Val2=1 -> result 3.
- Immediate rotate: shift_operand=0x4FF, MOV -> alu_result=0xFF000000. Store with shift_operand=0xFFF -> Val2=0x00000FFF.
- Backpressure: out_ready=0 for 3 cycles with in_valid held -> outputs stable and in_ready=0. Then out_ready=1 -> one transfer per cycle, no loss or duplication across 4 ops.
- Branch: pc=0x100, signed_imm=0xFFFFFF -> branch_addr=0xFC. pc=0xFFFFFFFC, signed_imm=1 -> 0x00000000 (wrap).
- EXEC_MUL_EN: reg1=0xFFFFFFFF, reg2=3 -> busy for 16 cycles, alu_result=0xFFFFFFFD. rst asserted in cycle 5 -> out_valid stays 0 and busy=0 next cycle.

Source files
------------

// File: rtl/exec_stage_pipe.sv
// rtl/exec_stage_pipe.sv - ARM execute stage: Val2 shifter, ALU, NZCV register, branch target, valid/ready output
// Optional radix-4 iterative multiplier on exe_cmd 0000 when EXEC_MUL_EN is defined.
module exec_stage_pipe #(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 24,
    parameter int PC_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        exe_cmd,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              s_bit,
    input  logic [PC_W-1:0]   pc,
    input  logic [DATA_W-1:0] reg1,
    input  logic [DATA_W-1:0] reg2,
    input  logic              imm,
    input  logic [11:0]       shift_operand,
    input  logic [IMM_W-1:0]  signed_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] alu_result,
    output logic [PC_W-1:0]   branch_addr,
    output logic [3:0]        status,
    output logic              busy
);
    localparam int MSB = DATA_W - 1;

    // Rotate amounts reach 31; for narrow datapaths fold them back into range.
    function automatic logic [DATA_W-1:0] f_ror(input logic [DATA_W-1:0] v, input logic [4:0] a);
        logic [2*DATA_W-1:0] d;
        logic [4:0]          m;
        m = (int'(a) >= DATA_W) ? a - 5'(DATA_W) : a;
        d = {v, v} >> m;
        return d[DATA_W-1:0];
    endfunction

    logic              r_out_valid;
    logic [DATA_W-1:0] r_alu_result;
    logic [PC_W-1:0]   r_branch;
    logic [3:0]        r_status;

    logic              w_idle;
    logic              w_is_mul;
    logic              w_mul_load;
    logic              w_out_free;
    logic              w_fire;
    logic [4:0]        w_amt;
    logic [DATA_W-1:0] w_val2;
    logic [DATA_W:0]   w_sum;
    logic [DATA_W-1:0] w_alu_res;
    logic              w_c;
    logic              w_v;
    logic              w_flag_op;
    logic [PC_W-1:0]   w_br_off;
    logic [PC_W-1:0]   w_branch;

    assign w_out_free = !r_out_valid || out_ready;
    assign in_ready   = w_idle && w_out_free;
    assign w_fire     = in_valid && in_ready;

    always_comb begin
        w_amt  = shift_operand[11:7];
        w_val2 = reg2;
        if (mem_read || mem_write) begin
            w_val2 = DATA_W'(shift_operand);
        end else if (imm) begin
            w_val2 = f_ror(DATA_W'(shift_operand[7:0]), {shift_operand[11:8], 1'b0});
        end else begin
            case (shift_operand[6:5])
                2'b00:   w_val2 = reg2 << w_amt;
                2'b01:   w_val2 = reg2 >> w_amt;
                2'b10:   w_val2 = $unsigned($signed(reg2) >>> w_amt);
                default: w_val2 = f_ror(reg2, w_amt);
            endcase
        end
    end

    always_comb begin
        w_sum     = '0;
        w_alu_res = '0;
        w_c       = r_status[1];
        w_v       = r_status[0];
        w_flag_op = 1'b1;
        case (exe_cmd)
            4'b0001: w_alu_res = w_val2;
            4'b1001: w_alu_res = ~w_val2;
            4'b0010, 4'b0011: begin
                w_sum     = {1'b0, reg1} + {1'b0, w_val2}
                          + {{DATA_W{1'b0}}, exe_cmd[0] & r_status[1]};
                w_alu_res = w_sum[MSB:0];
                w_c       = w_sum[DATA_W];
                w_v       = (reg1[MSB] == w_val2[MSB]) && (w_alu_res[MSB] != reg1[MSB]);
            end
            // a + ~b + 1 for SUB, a + ~b + C for SBC; carry out is NOT borrow
            4'b0100, 4'b0101: begin
                w_sum     = {1'b0, reg1} + {1'b0, ~w_val2}
                          + {{DATA_W{1'b0}}, ~exe_cmd[0] | r_status[1]};
                w_alu_res = w_sum[MSB:0];
                w_c       = w_sum[DATA_W];
                w_v       = (reg1[MSB] != w_val2[MSB]) && (w_alu_res[MSB] != reg1[MSB]);
            end
            4'b0110: w_alu_res = reg1 & w_val2;
            4'b0111: w_alu_res = reg1 | w_val2;
            4'b1000: w_alu_res = reg1 ^ w_val2;
            default: w_flag_op = 1'b0;
        endcase
    end

    assign w_br_off = PC_W'($signed(signed_imm));
    assign w_branch = pc + (w_br_off << 2);

`ifdef EXEC_MUL_EN
    localparam int HALF  = DATA_W / 2;
    localparam int CNT_W = $clog2(HALF + 1);

    typedef enum logic {ST_IDLE = 1'b0, ST_MUL = 1'b1} state_t;
    state_t r_state;
    state_t w_state_next;

    logic [DATA_W-1:0] r_mcand;
    logic [DATA_W-1:0] r_mplier;
    logic [DATA_W-1:0] r_acc;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_mul_s;
    logic [PC_W-1:0]   r_mul_br;
    logic [DATA_W-1:0] w_pp;
    logic              w_last;
    logic              w_done;
    logic [DATA_W-1:0] w_mul_res;

    assign w_is_mul = (exe_cmd == 4'b0000);
    assign w_idle   = (r_state == ST_IDLE);
    assign busy     = (r_state == ST_MUL);
    assign w_pp     = (r_mplier[0] ? r_mcand : '0)
                    + (r_mplier[1] ? {r_mcand[MSB-1:0], 1'b0} : '0);
    assign w_last   = (r_cnt == CNT_W'(HALF - 1));
    assign w_done   = (r_cnt == CNT_W'(HALF));
    // Final digit is folded in on the load edge; once parked, r_acc already holds the product.
    assign w_mul_res = w_done ? r_acc : r_acc + w_pp;

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_mul_load   = 1'b0;
        case (r_state)
            ST_IDLE: if (w_fire && w_is_mul) w_state_next = ST_MUL;
            ST_MUL: begin
                if ((w_last || w_done) && w_out_free) begin
                    w_mul_load   = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_mul_s  <= 1'b0;
            r_mul_br <= '0;
        end else if (w_fire && w_is_mul) begin
            r_mcand  <= reg1;
            r_mplier <= reg2;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_mul_s  <= s_bit;
            r_mul_br <= w_branch;
        end else if (r_state == ST_MUL && !w_done) begin
            r_acc    <= r_acc + w_pp;
            r_mcand  <= r_mcand << 2;
            r_mplier <= r_mplier >> 2;
            r_cnt    <= r_cnt + 1'b1;
        end
    end
`else
    assign w_is_mul   = 1'b0;
    assign w_idle     = 1'b1;
    assign w_mul_load = 1'b0;
    assign busy       = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_alu_result <= '0;
            r_branch     <= '0;
            r_status     <= '0;
        end else begin
            if (r_out_valid && out_ready) r_out_valid <= 1'b0;
            if (w_fire && !w_is_mul) begin
                r_out_valid  <= 1'b1;
                r_alu_result <= w_alu_res;
                r_branch     <= w_branch;
                if (s_bit && w_flag_op)
                    r_status <= {w_alu_res[MSB], (w_alu_res == '0), w_c, w_v};
            end
`ifdef EXEC_MUL_EN
            if (w_mul_load) begin
                r_out_valid  <= 1'b1;
                r_alu_result <= w_mul_res;
                r_branch     <= r_mul_br;
                if (r_mul_s)
                    r_status <= {w_mul_res[MSB], (w_mul_res == '0), r_status[1:0]};
            end
`endif
        end
    end

    assign out_valid   = r_out_valid;
    assign alu_result  = r_alu_result;
    assign branch_addr = r_branch;
    assign status      = r_status;
endmodule

// File: tb/tb_exec_stage_pipe.sv
// tb/tb_exec_stage_pipe.sv - scoreboard bench for exec_stage_pipe with a behavioural reference model
module tb_exec_stage_pipe;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  exe_cmd = '0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic        s_bit = 1'b0;
    logic [31:0] pc = '0;
    logic [31:0] reg1 = '0;
    logic [31:0] reg2 = '0;
    logic        imm = 1'b0;
    logic [11:0] shift_operand = '0;
    logic [23:0] signed_imm = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] alu_result;
    logic [31:0] branch_addr;
    logic [3:0]  status;
    logic        busy;

    exec_stage_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .exe_cmd(exe_cmd), .mem_read(mem_read), .mem_write(mem_write), .s_bit(s_bit),
        .pc(pc), .reg1(reg1), .reg2(reg2), .imm(imm), .shift_operand(shift_operand),
        .signed_imm(signed_imm), .out_valid(out_valid), .out_ready(out_ready),
        .alu_result(alu_result), .branch_addr(branch_addr), .status(status), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  cmd;
        bit          mr, mw, s, im;
        logic [31:0] p, r1, r2;
        logic [11:0] so;
        logic [23:0] si;
    } op_t;

    typedef struct {
        logic [31:0] res;
        logic [31:0] br;
        logic [3:0]  st;
    } exp_t;

    exp_t       q[$];
    logic [3:0] m_status = '0;
    int         total = 0;
    int         bad = 0;
    int         rdy_mode = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] ror_m(input logic [31:0] x, input int n);
        logic [31:0] y;
        y = x;
        for (int i = 0; i < n; i++) y = {y[0], y[31:1]};
        return y;
    endfunction

    // Reference: whole-number arithmetic; carry/overflow from range tests.
    task automatic model_push(input op_t o);
        logic [31:0] v2, res, br;
        longint      us, ls;
        bit          cin, c, v, flag;
        int          amt, off;
        exp_t        e;
        if (o.mr || o.mw) v2 = {20'd0, o.so};
        else if (o.im) v2 = ror_m({24'd0, o.so[7:0]}, 2 * int'(o.so[11:8]));
        else begin
            amt = int'(o.so[11:7]);
            case (o.so[6:5])
                2'd0:    v2 = o.r2 << amt;
                2'd1:    v2 = o.r2 >> amt;
                2'd2:    v2 = $unsigned($signed(o.r2) >>> amt);
                default: v2 = ror_m(o.r2, amt);
            endcase
        end
        cin = m_status[1]; c = m_status[1]; v = m_status[0]; flag = 1; res = '0;
        case (o.cmd)
            4'd1: res = v2;
            4'd9: res = ~v2;
            4'd2, 4'd3: begin
                us  = longint'(o.r1) + longint'(v2) + ((o.cmd == 4'd3 && cin) ? 1 : 0);
                ls  = longint'($signed(o.r1)) + longint'($signed(v2)) + ((o.cmd == 4'd3 && cin) ? 1 : 0);
                res = us[31:0];
                c   = us > 64'sh0_FFFF_FFFF;
                v   = (ls > 64'sd2147483647) || (ls < -64'sd2147483648);
            end
            4'd4, 4'd5: begin
                us  = longint'(o.r1) - longint'(v2) - ((o.cmd == 4'd5 && !cin) ? 1 : 0);
                ls  = longint'($signed(o.r1)) - longint'($signed(v2)) - ((o.cmd == 4'd5 && !cin) ? 1 : 0);
                res = us[31:0];
                c   = us >= 0;
                v   = (ls > 64'sd2147483647) || (ls < -64'sd2147483648);
            end
            4'd6: res = o.r1 & v2;
            4'd7: res = o.r1 | v2;
            4'd8: res = o.r1 ^ v2;
`ifdef EXEC_MUL_EN
            4'd0: res = o.r1 * o.r2;
`endif
            default: flag = 0;
        endcase
        if (o.s && flag) m_status = {res[31], res == 32'd0, c, v};
        off = int'($signed(o.si));
        br  = o.p + 32'(off * 4);
        e.res = res; e.br = br; e.st = m_status;
        q.push_back(e);
    endtask

    function automatic op_t mk(input logic [3:0] cmd, input bit mr, input bit mw, input bit s,
                               input logic [31:0] p, input logic [31:0] r1, input logic [31:0] r2,
                               input bit im, input logic [11:0] so, input logic [23:0] si);
        op_t o;
        o.cmd = cmd; o.mr = mr; o.mw = mw; o.s = s; o.p = p; o.r1 = r1; o.r2 = r2;
        o.im = im; o.so = so; o.si = si;
        return o;
    endfunction

    task automatic drive(input op_t o);
        int tries;
        @(negedge clk);
        exe_cmd = o.cmd; mem_read = o.mr; mem_write = o.mw; s_bit = o.s; pc = o.p;
        reg1 = o.r1; reg2 = o.r2; imm = o.im; shift_operand = o.so; signed_imm = o.si;
        in_valid = 1'b1;
        #1;
        tries = 0;
        while (!in_ready && tries < 200) begin
            @(negedge clk); #1;
            tries++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
        end else begin
            model_push(o);
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic chk_out(input string nm, input logic [31:0] er, input logic [3:0] es, input logic [31:0] eb);
        @(negedge clk); #3;
        chk({nm, "_valid"}, 32'(out_valid), 32'd1);
        chk({nm, "_res"}, alu_result, er);
        chk({nm, "_status"}, 32'(status), 32'(es));
        chk({nm, "_branch"}, branch_addr, eb);
    endtask

    task automatic wait_drain();
        int n;
        rdy_mode = 0;
        n = 0;
        while ((q.size() != 0 || out_valid) && n < 100) begin
            @(negedge clk); #3;
            n++;
        end
        chk("drain_empty", 32'(q.size()), 32'd0);
    endtask

    always @(negedge clk) begin
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 9) < 7);
            default: out_ready = 1'b0;
        endcase
    end

    always begin
        exp_t e;
        @(negedge clk); #2;
        if (!rst && out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_output", 32'(q.size()), 32'd1);
            end else begin
                e = q.pop_front();
                chk("sb_res", alu_result, e.res);
                chk("sb_branch", branch_addr, e.br);
                chk("sb_status", 32'(status), 32'(e.st));
            end
        end
    end

    initial begin
        #400000;
        bad++;
        $display("FAIL watchdog expired total=%0d", total);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        int lat, busy_cnt;
        op_t o;
        repeat (3) @(posedge clk);
        @(negedge clk); #2;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_alu_result", alu_result, 32'd0);
        chk("rst_branch", branch_addr, 32'd0);
        chk("rst_status", 32'(status), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;

        drive(mk(4'd2, 0, 0, 1, 32'h0, 32'h7FFF_FFFF, 32'h0, 1, 12'h001, 24'h0));
        chk_out("add_s", 32'h8000_0000, 4'b1001, 32'h0);
        drive(mk(4'd4, 0, 0, 1, 32'h0, 32'd5, 32'd5, 0, 12'h000, 24'h0));
        chk_out("sub_s", 32'h0, 4'b0110, 32'h0);
        drive(mk(4'd3, 0, 0, 0, 32'h0, 32'd1, 32'h0, 1, 12'h001, 24'h0));
        chk_out("adc", 32'd3, 4'b0110, 32'h0);
        drive(mk(4'd1, 0, 0, 0, 32'h0, 32'h0, 32'h0, 1, 12'h4FF, 24'h0));
        chk_out("mov_rot", 32'hFF00_0000, 4'b0110, 32'h0);
        drive(mk(4'd2, 0, 1, 0, 32'h0, 32'h0, 32'h0, 0, 12'hFFF, 24'h0));
        chk_out("store_val2", 32'h0000_0FFF, 4'b0110, 32'h0);
        drive(mk(4'd1, 0, 0, 0, 32'h100, 32'h0, 32'h0, 1, 12'h000, 24'hFFFFFF));
        chk_out("branch_back", 32'h0, 4'b0110, 32'h0000_00FC);
        drive(mk(4'd1, 0, 0, 0, 32'hFFFF_FFFC, 32'h0, 32'h0, 1, 12'h000, 24'h000001));
        chk_out("branch_wrap", 32'h0, 4'b0110, 32'h0);
        drive(mk(4'd9, 0, 0, 1, 32'h0, 32'h0, 32'h0, 1, 12'h000, 24'h0));
        chk_out("mvn_keep_cv", 32'hFFFF_FFFF, 4'b1010, 32'h0);
        drive(mk(4'd10, 0, 0, 1, 32'h0, 32'h1234, 32'h0, 1, 12'h055, 24'h0));
        chk_out("undef_op", 32'h0, 4'b1010, 32'h0);
`ifndef EXEC_MUL_EN
        drive(mk(4'd0, 0, 0, 1, 32'h0, 32'hFFFF_FFFF, 32'd3, 0, 12'h000, 24'h0));
        chk_out("op0_no_mul", 32'h0, 4'b1010, 32'h0);
`endif
        wait_drain();

        // Backpressure: first op parks in the output register for three cycles.
        rdy_mode = 2;
        fork
            begin
                drive(mk(4'd1, 0, 0, 0, 32'h0, 32'h0, 32'h0, 1, 12'h0AB, 24'h0));
                drive(mk(4'd1, 0, 0, 0, 32'h0, 32'h0, 32'h0, 1, 12'h0CD, 24'h0));
                drive(mk(4'd1, 0, 0, 0, 32'h0, 32'h0, 32'h0, 1, 12'h0EF, 24'h0));
                drive(mk(4'd1, 0, 0, 0, 32'h0, 32'h0, 32'h0, 1, 12'h012, 24'h0));
            end
            begin
                repeat (2) @(negedge clk);
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk); #2;
                    chk("bp_in_ready", 32'(in_ready), 32'd0);
                    chk("bp_out_valid", 32'(out_valid), 32'd1);
                    chk("bp_hold_res", alu_result, 32'h0000_00AB);
                end
                rdy_mode = 0;
            end
        join
        wait_drain();

`ifdef EXEC_MUL_EN
        drive(mk(4'd0, 0, 0, 1, 32'h40, 32'hFFFF_FFFF, 32'd3, 0, 12'h000, 24'h000002));
        lat = 0; busy_cnt = 0;
        while (lat < 40) begin
            @(negedge clk); #3;
            lat++;
            if (out_valid) break;
            if (busy) busy_cnt++;
        end
        chk("mul_latency", 32'(lat), 32'd17);
        chk("mul_busy_cycles", 32'(busy_cnt), 32'd16);
        chk("mul_res", alu_result, 32'hFFFF_FFFD);
        wait_drain();

        drive(mk(4'd0, 0, 0, 1, 32'h0, 32'h1234_5678, 32'h9ABC_DEF0, 0, 12'h000, 24'h0));
        repeat (4) @(negedge clk);
        rst = 1'b1;
        q.delete();
        m_status = '0;
        @(negedge clk); #2;
        chk("mul_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mul_rst_busy", 32'(busy), 32'd0);
        chk("mul_rst_status", 32'(status), 32'd0);
        rst = 1'b0;
        @(negedge clk); #2;
        chk("mul_rst_in_ready", 32'(in_ready), 32'd1);
`endif

        rdy_mode = 1;
        for (int i = 0; i < 300; i++) begin
            o = mk(4'($urandom_range(0, 15)), ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                   1'($urandom_range(0, 1)), $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)),
                   12'($urandom), 24'($urandom));
            if (i % 5 == 0) o.r1 = 32'h7FFF_FFFF + 32'($urandom_range(0, 2));
            drive(o);
        end
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
